// File: rtl/counter_load_sequencer_if.sv
// Load-side bundle between counter_load_sequencer and its counter/controller.
// Combinational wires only; no latency of its own.
// No backpressure: load strobes are fire-and-forget, the counter always accepts.
//
// Signal names are seen from the sequencer: *_i are sequencer inputs,
// *_o are sequencer outputs.
//   start_i     begin a sequence (honoured only when the sequencer is idle)
//   step_i      increment between successive load values
//   num_loads_i number of loads in the sequence
//   count_i     counter's current count
//   load_o      one-cycle load strobe to the counter
//   load_val_o  load value, zero whenever load_o is low
//   idx_o       index of the current or last-issued load
//   busy_o      sequence in progress
//   done_o      one-cycle end-of-sequence pulse
//   error_o     sticky watchdog error
interface counter_load_sequencer_if;
    logic       start_i;
    logic [3:0] step_i;
    logic [3:0] num_loads_i;
    logic [3:0] count_i;
    logic       load_o;
    logic [3:0] load_val_o;
    logic [3:0] idx_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    // Sequencer side.
    modport master (
        input  start_i, step_i, num_loads_i, count_i,
        output load_o, load_val_o, idx_o, busy_o, done_o, error_o
    );

    // Controller / counter side.
    modport slave (
        output start_i, step_i, num_loads_i, count_i,
        input  load_o, load_val_o, idx_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/counter_load_sequencer.sv
// Issues loads 0, step, 2*step, ... to a 4-bit up-counter, waiting for 4'hF after each.
// Latency: start sampled on one edge gives load_o in the next cycle; done_o one cycle after the last terminal count.
// No backpressure: start_i is ignored while busy; a per-load watchdog ends a stuck sequence with error_o.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts any sequence without a done pulse
//   bus    counter_load_sequencer_if.master (start/step/num_loads/count in,
//          load/load_val/idx/busy/done/error out)
module counter_load_sequencer #(
    parameter int WDOG_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    counter_load_sequencer_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Wide enough to hold WDOG_CYCLES itself, so the compare below never wraps.
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [3:0]    num_q, num_d;
    logic [3:0]    idx_q, idx_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          error_q, error_d;

    logic [3:0]    load_val;
    logic          last_load;

    // Only the low nibble of idx*step is ever used; truncating the product is
    // exactly the mod-16 wrap of the load value.
    assign load_val  = 4'(idx_q * step_q);

    // Five-bit compare keeps idx+1 from wrapping.
    assign last_load = ({1'b0, idx_q} + 5'd1) == {1'b0, num_q};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        num_d   = num_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    step_d  = bus.step_i;
                    num_d   = bus.num_loads_i;
                    idx_d   = 4'd0;
                    error_d = 1'b0;
                    state_d = (bus.num_loads_i == 4'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WW'(1);
                // Terminal count wins over the watchdog in the same cycle, so a
                // load of 0 (16 WAIT cycles) never trips the default timeout.
                if (bus.count_i == 4'hF) begin
                    if (last_load) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                    // This is the WDOG_CYCLES-th WAIT cycle: give up on the rest.
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 4'd0;
            num_q   <= 4'd0;
            idx_q   <= 4'd0;
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    // All outputs decode straight from registered state.
    assign bus.load_o     = (state_q == S_LOAD);
    assign bus.load_val_o = (state_q == S_LOAD) ? load_val : 4'd0;
    assign bus.idx_o      = idx_q;
    assign bus.busy_o     = (state_q == S_LOAD) || (state_q == S_WAIT);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.error_o    = error_q;
endmodule

// File: tb/tb_counter_load_sequencer.sv
module tb_counter_load_sequencer;
    localparam int WDOG = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    counter_load_sequencer_if bus();

    counter_load_sequencer #(.WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter beside the sequencer: ideal loadable up-counter, or stuck at a value.
    logic [3:0] cnt       = 4'd0;
    logic       stuck_en  = 1'b0;
    logic [3:0] stuck_val = 4'd0;
    always @(posedge clk) cnt <= bus.load_o ? bus.load_val_o : cnt + 4'd1;
    assign bus.count_i = stuck_en ? stuck_val : cnt;

    // Expected output events, keyed by absolute cycle number.
    typedef struct {
        bit         is_done;
        int         cyc;
        logic [3:0] val;
        bit         err;
        logic [3:0] idx;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   busy_lo = 1;
    int   busy_hi = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push_ev(bit d, int c, logic [3:0] v, bit er, logic [3:0] ix);
        exp_t e;
        e.is_done = d;
        e.cyc     = c;
        e.val     = v;
        e.err     = er;
        e.idx     = ix;
        exp_q.push_back(e);
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                chk(mon_e.is_done ? "missed_done_cycle" : "missed_load_cycle", cyc, mon_e.cyc);
            end
            if (bus.load_o || bus.done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind_done", int'(bus.done_o), int'(mon_e.is_done));
                    chk("event_cycle", cyc, mon_e.cyc);
                    if (mon_e.is_done) begin
                        chk("done_error", int'(bus.error_o), int'(mon_e.err));
                        chk("done_idx", int'(bus.idx_o), int'(mon_e.idx));
                    end else begin
                        chk("load_val", int'(bus.load_val_o), int'(mon_e.val));
                    end
                end
            end else begin
                chk("load_val_zero_when_idle", int'(bus.load_val_o), 0);
            end
            chk("busy", int'(bus.busy_o), int'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Called right after a falling edge with the DUT idle. Builds the expected
    // event list from the sequence rules: load i carries (i*step) mod 16; an
    // ideal counter reaches F after 16-val WAIT cycles; a stuck counter reaches
    // it after one cycle if stuck at F, never otherwise (watchdog fires after WDOG).
    task automatic start_seq(input logic [3:0] step, input logic [3:0] num,
                             input bit stuck, input logic [3:0] sval, input bit poke);
        int         n, t, wait_n, k;
        bit         timed_out;
        logic [3:0] v, last_idx;
        n         = cyc;
        t         = 1;
        timed_out = 1'b0;
        last_idx  = 4'd0;
        stuck_en  = stuck;
        stuck_val = sval;
        bus.start_i     = 1'b1;
        bus.step_i      = step;
        bus.num_loads_i = num;
        for (int i = 0; i < int'(num) && !timed_out; i++) begin
            v        = 4'((i * int'(step)) % 16);
            last_idx = 4'(i);
            push_ev(1'b0, n + t, v, 1'b0, 4'd0);
            if (stuck) wait_n = (sval == 4'hF) ? 1 : WDOG + 1;
            else       wait_n = 16 - int'(v);
            if (wait_n > WDOG) begin
                t += 1 + WDOG;
                timed_out = 1'b1;
            end else begin
                t += 1 + wait_n;
            end
        end
        push_ev(1'b1, n + t, 4'd0, timed_out, last_idx);
        busy_lo = n + 1;
        busy_hi = n + t - 1;
        @(negedge clk);
        bus.start_i     = 1'b0;
        bus.step_i      = 4'($urandom);
        bus.num_loads_i = 4'($urandom);
        chk("error_cleared_after_start", int'(bus.error_o), 0);
        // Start pulse while LOAD/WAIT must be ignored.
        if (poke && busy_hi >= n + 2) begin
            k = $urandom_range(busy_hi, n + 2);
            while (cyc < k) @(negedge clk);
            bus.start_i     = 1'b1;
            bus.step_i      = 4'($urandom);
            bus.num_loads_i = 4'($urandom);
            @(negedge clk);
            bus.start_i = 1'b0;
        end
    endtask

    // Returns at the first IDLE cycle after done_o.
    task automatic wait_idle();
        int budget;
        budget = 600;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            chk("sequence_timeout_pending_events", exp_q.size(), 0);
            exp_q.delete();
            busy_lo = 1;
            busy_hi = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_load"},     int'(bus.load_o), 0);
        chk({tag, "_load_val"}, int'(bus.load_val_o), 0);
        chk({tag, "_idx"},      int'(bus.idx_o), 0);
        chk({tag, "_busy"},     int'(bus.busy_o), 0);
        chk({tag, "_done"},     int'(bus.done_o), 0);
        chk({tag, "_error"},    int'(bus.error_o), 0);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.step_i      = 4'd0;
        bus.num_loads_i = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        // Baseline: loads at cycles 1, 18, 32 (0, 3, 6); done at 43.
        start_seq(4'd3, 4'd3, 1'b0, 4'd0, 1'b0);
        wait_idle();
        // Zero loads: done in cycle 1, never busy.
        start_seq(4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
        wait_idle();
        // Wrap: 0, 5, A, F; the F segment has a single WAIT cycle.
        start_seq(4'd5, 4'd4, 1'b0, 4'd0, 1'b0);
        wait_idle();
        // Watchdog: counter stuck at 0, done at 18 with error and idx 0.
        start_seq(4'd1, 4'd2, 1'b1, 4'd0, 1'b0);
        wait_idle();
        chk("error_sticky_in_idle", int'(bus.error_o), 1);
        // Back-to-back start in the IDLE cycle after done; also clears error.
        start_seq(4'd4, 4'd1, 1'b0, 4'd0, 1'b0);
        wait_idle();
        // Start while busy is ignored; step 6 reaches 3*6 mod 16 = 2.
        start_seq(4'd6, 4'd4, 1'b0, 4'd0, 1'b1);
        wait_idle();

        // Reset during the second WAIT segment (idx=1): everything clears, no done.
        start_seq(4'd3, 4'd3, 1'b0, 4'd0, 1'b0);
        repeat (19) @(negedge clk);
        chk("pre_reset_idx", int'(bus.idx_o), 1);
        reset = 1'b1;
        exp_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        @(negedge clk);
        check_all_zero("mid_seq_reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            start_seq(4'($urandom), 4'($urandom), ($urandom_range(3, 0) == 0),
                      4'($urandom), 1'($urandom));
            wait_idle();
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
